// File: rtl/mem_pkg.sv
// Shared encodings for the memory initiator: request sizes, FSM states and
// the default responder read latency.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: alignment check, byte-enable and store-data
// replication, and load-data shift/mask/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic        misalign,
    output logic [3:0]  b_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_in >> {off, 3'b000};
        misalign  = 1'b0;
        b_en      = 4'b0000;
        wdata_rep = wdata_in;
        rdata_ext = shifted;
        case (size)
            SZ_BYTE: begin
                b_en      = 4'b0001 << off;
                wdata_rep = {4{wdata_in[7:0]}};
                rdata_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                misalign  = off[0];
                b_en      = 4'b0011 << off;
                wdata_rep = {2{wdata_in[15:0]}};
                rdata_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                misalign  = |off;
                b_en      = 4'b1111;
                wdata_rep = wdata_in;
                rdata_ext = shifted;
            end
            default: begin
                // size 11 is never legal; no lanes, no data
                misalign  = 1'b1;
                b_en      = 4'b0000;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator driving a byte-enabled SRAM port,
// with stall handling, sticky error capture and load-data extension.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | req_ready high, waiting for a request
//   ACCESS  | request driven on the mem port; counts unstalled cycles
//   CAPTURE | load only: w_en low, latch extended data on first unstalled edge
//   RESP    | one-cycle rsp_valid pulse, enables low
module mem_initiator
    import mem_pkg::*;
#(
    parameter int addr_w = 32,
    parameter int data_w = 32,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              gclk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [addr_w-1:0] req_addr,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [data_w-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [data_w-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [addr_w-1:0] mem_addr,
    output logic [data_w-1:0] mem_wdata,
    output logic [3:0]        mem_b_en,
    output logic              mem_w_en,
    input  logic [data_w-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_error
);

    localparam int               CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             err_acc;
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_signed;
    logic             r_wen;

    logic [1:0]       al_off;
    logic [1:0]       al_size;
    logic             al_sgn;
    logic             misalign;
    logic [3:0]       al_b_en;
    logic [31:0]      al_wdata;
    logic [31:0]      al_rdata;
    logic             err_now;

    // In IDLE the aligner looks at the incoming request, afterwards at the held one.
    assign al_off    = (state == IDLE) ? req_addr[1:0] : r_off;
    assign al_size   = (state == IDLE) ? req_size      : r_size;
    assign al_sgn    = (state == IDLE) ? req_signed    : r_signed;
    assign err_now   = err_acc | mem_error;
    assign req_ready = (state == IDLE);

    mem_lane_align u_align (
        .off       (al_off),
        .size      (al_size),
        .sgn       (al_sgn),
        .wdata_in  (req_wdata),
        .rdata_in  (mem_rdata),
        .misalign  (misalign),
        .b_en      (al_b_en),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            err_acc   <= 1'b0;
            r_off     <= 2'b00;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_wen     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_b_en  <= 4'b0000;
            mem_w_en  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_error <= 1'b0;
                    if (req_valid) begin
                        r_off     <= req_addr[1:0];
                        r_size    <= req_size;
                        r_signed  <= req_signed;
                        r_wen     <= req_wen;
                        mem_addr  <= {req_addr[addr_w-1:2], 2'b00};
                        mem_wdata <= al_wdata;
                        cnt       <= '0;
                        err_acc   <= 1'b0;
                        if (misalign) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            mem_b_en <= al_b_en;
                            mem_w_en <= req_wen;
                        end
                    end
                end
                ACCESS: begin
                    err_acc <= err_now;
                    if (!mem_stall) begin
                        cnt <= cnt + 1'b1;
                        if (r_wen) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= err_now;
                            rsp_rdata <= '0;
                            mem_b_en  <= 4'b0000;
                            mem_w_en  <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state    <= CAPTURE;
                            mem_w_en <= 1'b0;
                        end
                    end
                end
                CAPTURE: begin
                    err_acc <= err_now;
                    if (!mem_stall) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= err_now;
                        rsp_rdata <= err_now ? '0 : al_rdata;
                        mem_b_en  <= 4'b0000;
                        mem_w_en  <= 1'b0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_error <= 1'b0;
                    err_acc   <= 1'b0;
                    cnt       <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator: a byte-array reference memory predicts
// every response, a negedge monitor checks the mem port and responses.
module tb_mem_initiator;
    import mem_pkg::*;

    localparam int RD_LAT_TB = 2;

    logic        gclk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_b_en;
    logic        mem_w_en;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_error;

    mem_initiator #(.addr_w(32), .data_w(32), .RD_LAT(RD_LAT_TB)) dut (
        .gclk       (gclk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_b_en   (mem_b_en),
        .mem_w_en   (mem_w_en),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .mem_error  (mem_error)
    );

    typedef struct {
        int          t0;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  b_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mj;
    logic [31:0] sram [64];
    logic [7:0]  ref_bytes [256];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // SRAM responder: combinational read, byte-enabled write while w_en is high
    assign mem_rdata = sram[mem_addr[7:2]];
    always @(posedge gclk) begin
        if (pl_en) sram[pl_idx] <= pl_val;
        else if (mem_w_en) sram[mem_addr[7:2]] <= merge(sram[mem_addr[7:2]], mem_wdata, mem_b_en);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        for (int i = 0; i < 4; i++) ref_bytes[4*idx + i] = val[8*i +: 8];
        pl_idx = 6'(idx);
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge gclk);
        #1 pl_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle after RESP.
    task automatic issue(input logic [7:0] a, input logic [1:0] sz, input logic w,
                         input logic sg, input logic [31:0] wd,
                         input int s, input int k, input int e);
        exp_t   it;
        int     n;
        bit     legal;
        int     base;
        int     g;
        longint v;
        n     = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
        legal = (sz != 2'b11) && ((int'(a) % n) == 0);
        if (!legal) begin
            k = 0;
            e = 0;
        end
        base     = !legal ? 1 : (w ? 2 : RD_LAT_TB + 2);
        it.lat   = base + k;
        it.err   = !legal || (e >= 1 && e < it.lat);
        it.addr  = {24'h0, a & 8'hFC};
        it.wen   = w;
        it.b_en  = 4'b0000;
        it.wdata = 32'h0;
        it.rdata = 32'h0;
        if (legal) begin
            for (int i = 0; i < n; i++) it.b_en[(int'(a) % 4) + i] = 1'b1;
            for (int l = 0; l < 4; l++) it.wdata[8*l +: 8] = wd[8*(l % n) +: 8];
            if (!w) begin
                v = 0;
                for (int i = 0; i < n; i++)
                    v = v + (longint'(ref_bytes[(int'(a) + i) % 256]) << (8*i));
                if (sg && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
                if (!it.err) it.rdata = v[31:0];
            end else begin
                for (int i = 0; i < n; i++) ref_bytes[(int'(a) + i) % 256] = wd[8*i +: 8];
            end
        end
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge gclk);
            g++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = {24'h0, a};
        req_wen    = w;
        req_size   = sz;
        req_signed = sg;
        req_wdata  = wd;
        it.t0      = cyc;
        q.push_back(it);
        for (int j = 1; j <= it.lat; j++) begin
            @(negedge gclk);
            if (j == 1) begin
                req_valid  = 1'b0;
                req_addr   = $urandom;
                req_wen    = 1'($urandom);
                req_size   = 2'($urandom);
                req_signed = 1'($urandom);
                req_wdata  = $urandom;
            end
            mem_stall = (k > 0) && (j >= s) && (j < s + k);
            mem_error = (j == e);
        end
        @(negedge gclk);
        mem_stall = 1'b0;
        mem_error = 1'b0;
    endtask

    always @(negedge gclk) begin
        if (resetn) begin
            if (q.size() > 0) begin
                mj = cyc - q[0].t0;
                if (rsp_valid) begin
                    check("rsp_latency", 32'(mj), 32'(q[0].lat));
                    check("rsp_rdata", rsp_rdata, q[0].rdata);
                    check("rsp_error", 32'(rsp_error), 32'(q[0].err));
                    check("resp_b_en", 32'(mem_b_en), 32'd0);
                    check("resp_w_en", 32'(mem_w_en), 32'd0);
                    void'(q.pop_front());
                end else if (mj >= 1 && mj < q[0].lat) begin
                    check("access_b_en", 32'(mem_b_en), 32'(q[0].b_en));
                    check("access_addr", mem_addr, q[0].addr);
                    check("access_w_en", 32'(mem_w_en), 32'(q[0].wen));
                    if (q[0].wen) check("access_wdata", mem_wdata, q[0].wdata);
                end else if (mj > q[0].lat) begin
                    check("rsp_timeout", 32'(mj), 32'(q[0].lat));
                    void'(q.pop_front());
                end
            end else if (rsp_valid) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]  ra;
    logic [1:0]  rsz;
    logic [31:0] rwd;
    logic        rw;
    logic        rsg;
    int          rr, rbase, rs, rk, re;

    initial begin
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_wen    = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_wdata  = 32'h0;
        mem_stall  = 1'b0;
        mem_error  = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_b_en", 32'(mem_b_en), 32'd0);
        check("rst_mem_w_en", 32'(mem_w_en), 32'd0);
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        @(negedge gclk);
        resetn = 1'b1;
        @(negedge gclk);

        set_word(4, 32'hDEADBEEF);
        @(negedge gclk);
        issue(8'h10, SZ_WORD, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        set_word(4, 32'h80FF1234);
        @(negedge gclk);
        issue(8'h13, SZ_BYTE, 1'b0, 1'b1, 32'h0, 1, 0, 0);
        issue(8'h13, SZ_BYTE, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        issue(8'h12, SZ_HALF, 1'b0, 1'b1, 32'h0, 1, 0, 0);
        set_word(8, 32'h55667788);
        @(negedge gclk);
        issue(8'h22, SZ_HALF, 1'b1, 1'b0, 32'h1234ABCD, 1, 0, 0);
        issue(8'h20, SZ_WORD, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        issue(8'h06, SZ_WORD, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        issue(8'h11, 2'b11, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        issue(8'h10, SZ_WORD, 1'b0, 1'b0, 32'h0, 1, 3, 0);
        issue(8'h10, SZ_WORD, 1'b0, 1'b0, 32'h0, 1, 0, 1);
        issue(8'h10, SZ_WORD, 1'b0, 1'b0, 32'h0, 3, 2, 5);
        issue(8'h31, SZ_BYTE, 1'b1, 1'b0, 32'h000000A5, 1, 2, 0);
        issue(8'h30, SZ_WORD, 1'b0, 1'b0, 32'h0, 1, 0, 4);

        // reset while in CAPTURE: cycles 1-2 are ACCESS, cycle 3 is CAPTURE
        req_valid  = 1'b1;
        req_addr   = 32'h40;
        req_wen    = 1'b0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        @(negedge gclk);
        req_valid = 1'b0;
        @(negedge gclk);
        @(negedge gclk);
        check("capture_b_en", 32'(mem_b_en), 32'hF);
        #2 resetn = 1'b0;
        #1;
        check("arst_b_en", 32'(mem_b_en), 32'd0);
        check("arst_w_en", 32'(mem_w_en), 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        resetn = 1'b1;
        @(negedge gclk);
        issue(8'h40, SZ_WORD, 1'b0, 1'b0, 32'h0, 1, 0, 0);

        for (int t = 0; t < 90; t++) begin
            rr  = int'($urandom_range(0, 9));
            rsz = (rr < 3) ? SZ_BYTE : (rr < 6) ? SZ_HALF : (rr < 9) ? SZ_WORD : 2'b11;
            ra  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == SZ_HALF) ra[0] = 1'b0;
                if (rsz == SZ_WORD) ra[1:0] = 2'b00;
            end
            rw    = 1'($urandom_range(0, 1));
            rsg   = 1'($urandom_range(0, 1));
            rwd   = $urandom;
            rbase = rw ? 2 : RD_LAT_TB + 2;
            rs    = int'($urandom_range(1, rbase - 1));
            rk    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : 0;
            re    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, rbase + rk)) : 0;
            issue(ra, rsz, rw, rsg, rwd, rs, rk, re);
        end

        repeat (5) @(negedge gclk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Memory-side initiator for the multi-cycle core: accepts one load/store request at a time from the core datapath and drives the byte-enabled SRAM port (addr, wdata, b_en, w_en), honouring stall and error. For loads it aligns and sign- or zero-extends the returned word. It sits between the core's load/store/fetch logic and the `sram` responder in the testbench memory system.

## Interface

Parameters:
- `addr_w`, 32, address width in bits.
- `data_w`, 32, data width in bits; only 32 is supported.
- `RD_LAT`, 2, unstalled request cycles the responder needs before `mem_rdata` is stable.

Ports:
- `gclk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_addr` in addr_w: byte address.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load data.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: load result, extended; 0 for stores and errors.
- `rsp_error` out 1: misaligned, illegal size, or responder error.
- `mem_addr` out addr_w: word-aligned address, `{req_addr[addr_w-1:2], 2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_b_en` out 4: byte lane enables.
- `mem_w_en` out 1: write enable.
- `mem_rdata` in 32: responder read data.
- `mem_stall` in 1: responder stall.
- `mem_error` in 1: responder error.

## Operation

The request is registered on acceptance. All `mem_*` outputs are driven from registers and held stable for the whole access.

Alignment:
- Half-word requests require `addr[0]=0`.
- Word requests require `addr[1:0]=0`.
- Size 11 is illegal.
- A misaligned or illegal request makes no memory access: `mem_b_en` stays 0, and the block goes straight to RESP with `rsp_error=1` and `rsp_rdata=0`.

Lane generation (off = `addr[1:0]`):
- Byte: `b_en = 4'b0001 << off`, wdata = `{4{wdata[7:0]}}`.
- Half: `b_en = 4'b0011 << off`, wdata = `{2{wdata[15:0]}}`.
- Word: `b_en = 4'b1111`, wdata = wdata.

Load data: `(mem_rdata >> 8*off)`, masked to the requested size, then sign-extended if `req_signed`, else zero-extended.

FSM states:
- IDLE: `req_ready=1`; on accept go to RESP if misaligned, else to ACCESS with cnt=0.
- ACCESS: drive `mem_addr`, `mem_b_en`, `mem_wdata`, and `mem_w_en=req_wen`.
  - cnt increments only in cycles with `mem_stall=0`.
  - Store: leave after 1 unstalled cycle, to RESP.
  - Load: leave after RD_LAT unstalled cycles, to CAPTURE.
- CAPTURE (loads only): keep driving the request with `w_en=0`. At the first edge with `mem_stall=0`, register the extended data and go to RESP.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE. `mem_b_en` and `mem_w_en` are 0.

Error handling: `mem_error` is OR-accumulated into a sticky flag during ACCESS and CAPTURE. That flag becomes `rsp_error`; when it is set, `rsp_rdata` is forced to 0.

## Timing

- Reset (async, immediate): state IDLE. `req_ready=1`; `rsp_valid`, `rsp_rdata`, `rsp_error`, `mem_addr`, `mem_wdata`, `mem_b_en`, `mem_w_en`, cnt and error flag all 0.
- Acceptance edge is E0; `mem_b_en` is nonzero in the cycle after E0.
- Unstalled latency (E0 to the `rsp_valid` cycle):
  - load: RD_LAT+2 cycles (4 by default);
  - store: 2 cycles;
  - misaligned/illegal: 1 cycle.
- Each stalled cycle in ACCESS or CAPTURE adds exactly one cycle. Outputs are held unchanged during stall.
- `rsp_valid` has no backpressure. The next request is accepted no earlier than the edge ending the first IDLE cycle after RESP.
- `req_*` inputs are ignored outside IDLE.
- Reset mid-access: abandon the transaction, produce no response, and deassert all enables immediately.
- `mem_error` asserted in a stalled cycle still counts.
- cnt is sized `$clog2(RD_LAT+1)` and never wraps.

## Structure

- Package `mem_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum (IDLE/ACCESS/CAPTURE/RESP), default RD_LAT.
- Sub-module `mem_lane_align` (combinational):
  - alignment check;
  - b_en and wdata replication;
  - rdata shift, mask and extend.
- `mem_initiator` holds the FSM, the counter and the registers.

## Test plan

- Word load, addr 0x10, memory word 0xDEADBEEF, stall 0 -> `rsp_valid` 4 cycles after accept, `rsp_rdata=0xDEADBEEF`, `mem_b_en=4'b1111`.
- Signed byte load, addr 0x13, word 0x80FF1234 -> `b_en=4'b1000`, `rsp_rdata=0xFFFFFF80`; the same load unsigned -> `0x00000080`.
- Half store 0xABCD at addr 0x22 -> `b_en=4'b1100`, `mem_wdata=0xABCDABCD`, `w_en=1` for one cycle. Reading back the word gives `0xABCDxxxx` with the low half unchanged.
- Word load at addr 0x06 -> no `b_en` ever asserted; `rsp_valid` 1 cycle after accept with `rsp_error=1` and `rsp_rdata=0`.
- `mem_stall` held high for 3 cycles during ACCESS of a word load -> `rsp_valid` at 7 cycles, correct data, request outputs stable throughout.
- `resetn` low during CAPTURE -> all outputs 0 at once and no `rsp_valid`. The next load after reset completes normally.
- `mem_error=1` for one cycle during ACCESS -> `rsp_error=1`, `rsp_rdata=0`.
